// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: datapath width and FSM state encoding.
package div_pkg;

    // Datapath width shared with the lib adders; default operand width of the divider.
    localparam int unsigned DATAPATH_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Valid/ready request and response bundle for seq_restoring_divider.
interface seq_restoring_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Producer/consumer side.
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/nbit_adder_subtractor.sv
// Ripple-carry adder/subtractor: sum = a + b when sub=0, a - b (two's complement) when sub=1.
module nbit_adder_subtractor #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);
    logic carry;
    logic bx;

    // Subtract inverts b and injects the +1 through the carry-in.
    always_comb begin
        carry = sub;
        bx    = 1'b0;
        sum   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            bx     = b[i] ^ sub;
            sum[i] = a[i] ^ bx ^ carry;
            carry  = (a[i] & bx) | (carry & (a[i] ^ bx));
        end
    end
endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DATAPATH_W,
    parameter int unsigned CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_restoring_divider_if.slave bus
);
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // After every restoring step R < D, so the stored remainder never needs its MSB.
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   t;
    logic             t_neg;
    logic [WIDTH-1:0] r_iter;
    logic [WIDTH-1:0] q_iter;

    assign r_shift = {r_q, q_q[WIDTH-1]};

    nbit_adder_subtractor #(
        .N (WIDTH + 1)
    ) u_trial_sub (
        .a   (r_shift),
        .b   ({1'b0, d_q}),
        .sub (1'b1),
        .sum (t)
    );

    assign t_neg  = t[WIDTH];
    assign r_iter = t_neg ? r_shift[WIDTH-1:0] : t[WIDTH-1:0];
    assign q_iter = {q_q[WIDTH-2:0], ~t_neg};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    d_d   = bus.divisor;
                    q_d   = bus.dividend;
                    r_d   = '0;
                    cnt_d = '0;
                    if (bus.divisor == '0) begin
                        state_d     = S_DONE;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                r_d   = r_iter;
                q_d   = q_iter;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = S_DONE;
                    quotient_d  = q_iter;
                    remainder_d = r_iter;
                    dbz_d       = 1'b0;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        out_valid_d = (state_d == S_DONE);
        in_ready_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and random checks of seq_restoring_divider at WIDTH=8.
module tb_seq_restoring_divider;
    import div_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(
        .WIDTH (W),
        .CNT_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one divide with out_ready high and check latency, result and handoff.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                           input int elat);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready_idle"}, bus.in_ready, 1);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, elat);
        check({tag, ".q"}, bus.quotient, eq);
        check({tag, ".r"}, bus.remainder, er);
        check({tag, ".dbz"}, bus.div_by_zero, edbz);
        @(negedge clk);
        check({tag, ".out_valid_drop"}, bus.out_valid, 0);
        check({tag, ".in_ready_back"}, bus.in_ready, 1);
    endtask

    initial begin
        int lat;
        int found;
        int t0;
        int t1;
        logic [W-1:0] a;
        logic [W-1:0] b;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.in_ready", bus.in_ready, 1);
        check("rst.out_valid", bus.out_valid, 0);
        check("rst.q", bus.quotient, 0);
        check("rst.r", bus.remainder, 0);
        check("rst.dbz", bus.div_by_zero, 0);
        rst = 1'b0;

        run_div("200/7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9);
        run_div("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
        run_div("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9);
        run_div("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9);
        run_div("0/13", 8'd0, 8'd13, 8'd0, 8'd0, 1'b0, 9);
        run_div("100/0", 8'd100, 8'd0, 8'd255, 8'd100, 1'b1, 1);
        run_div("128/2", 8'd128, 8'd2, 8'd64, 8'd0, 1'b0, 9);

        // Backpressure: hold out_ready low while the result waits; stray requests are ignored.
        @(negedge clk);
        bus.dividend  = 8'd77;
        bus.divisor   = 8'd5;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.dividend = 8'd3;
        bus.divisor  = 8'd1;
        check("bp.in_ready_busy", bus.in_ready, 0);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp.latency", lat, 9);
        for (int i = 0; i < 4; i++) begin
            check("bp.hold_valid", bus.out_valid, 1);
            check("bp.hold_q", bus.quotient, 15);
            check("bp.hold_r", bus.remainder, 2);
            check("bp.in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp.out_valid_drop", bus.out_valid, 0);
        check("bp.in_ready_back", bus.in_ready, 1);

        // Reset in the middle of CALC discards the operation.
        @(negedge clk);
        bus.dividend = 8'd200;
        bus.divisor  = 8'd7;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid.in_ready", bus.in_ready, 1);
        check("rstmid.out_valid", bus.out_valid, 0);
        repeat (12) begin
            @(negedge clk);
            check("rstmid.no_output", bus.out_valid, 0);
        end
        run_div("9/3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9);

        // Back-to-back: in_valid and out_ready held high continuously.
        @(negedge clk);
        bus.dividend  = 8'd50;
        bus.divisor   = 8'd6;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        found = 0;
        t0 = 0;
        t1 = 0;
        for (int i = 0; i < 40 && found < 2; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                check("b2b.q", bus.quotient, 8);
                check("b2b.r", bus.remainder, 2);
                if (found == 0) t0 = cyc;
                else t1 = cyc;
                found++;
            end
        end
        bus.in_valid = 1'b0;
        check("b2b.count", found, 2);
        check("b2b.spacing", t1 - t0, 10);
        repeat (12) @(negedge clk);

        // Random operands against the golden / and %.
        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom_range(0, 255));
            b = (i % 64 == 0) ? '0 : W'($urandom_range(0, 255));
            if (b == '0) run_div("rand", a, b, '1, a, 1'b1, 1);
            else run_div("rand", a, b, a / b, a % b, 1'b0, 9);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
